// File: rtl/fifo_to_axis_pkg.sv
// Shared definitions for the packet FIFO format: state encodings and header
// field placement, used by both the FIFO writer and the AXI Stream reader.
package fifo_to_axis_pkg;

  localparam logic [0:0] ST_HDR  = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  localparam int HDR_FIELD_W = 64;
  localparam int TUSER_LO    = 0;
  localparam int TS_LO       = 64;

endpackage

// File: rtl/axis_out_buf.sv
// Two-entry skid buffer with registered outputs: a beat accepted in one cycle
// is presented on the next, and a full beat per cycle flows while out_ready holds.
module axis_out_buf #(
  parameter int W = 8
) (
  input  logic         axi_aclk,
  input  logic         axi_aresetn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         skid_valid;
  logic [W-1:0] skid_data;

  // Readiness depends only on registered state, so the upstream pop never
  // waits on a combinational path from m_axis_tready.
  assign in_ready = !skid_valid;

  // NOTE: the payload registers are reset too, because the stream outputs are
  // required to read as zero during reset, not merely be qualified by tvalid.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/fifo_to_axis.sv
// Reads header/data words from a first-word-fall-through FIFO and emits them
// as AXI Stream packets, tagging every beat with the header's tuser field.
module fifo_to_axis
  import fifo_to_axis_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DATA_WIDTH      = C_M_AXIS_DATA_WIDTH + C_M_AXIS_DATA_WIDTH / 8
) (
  input  logic                             axi_aclk,
  input  logic                             axi_aresetn,
  input  logic [FIFO_DATA_WIDTH-1:0]       fifo_dout,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [63:0]                      pkt_timestamp,
  output logic [31:0]                      pkt_count,
  output logic [15:0]                      err_count
);

  localparam int DATA_W  = C_M_AXIS_DATA_WIDTH;
  localparam int STRB_W  = C_M_AXIS_DATA_WIDTH / 8;
  localparam int TUSER_W = C_M_AXIS_TUSER_WIDTH;
  localparam int BEAT_W  = TUSER_W + 1 + STRB_W + DATA_W;
  localparam logic [STRB_W-1:0] STRB_ONE = STRB_W'(1);

  logic [0:0]         state;
  logic [TUSER_W-1:0] tuser_q;
  logic [63:0]        ts_q;

  logic [STRB_W-1:0]  enc;
  logic               enc_onehot;
  logic               beat_last;
  logic               malformed;
  logic [STRB_W-1:0]  beat_strb;

  logic               hdr_pop;
  logic               data_pop;
  logic               buf_in_ready;
  logic [BEAT_W-1:0]  buf_out;

  assign enc = fifo_dout[DATA_W +: STRB_W];

  // NOTE: every signal assigned here gets a default first so that no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    enc_onehot = 1'b0;
    beat_strb  = '1;
    beat_last  = 1'b0;
    malformed  = 1'b0;
    if (enc != '0) begin
      enc_onehot = (enc & (enc - STRB_ONE)) == '0;
      beat_last  = 1'b1;
      malformed  = !enc_onehot;
      // One-hot bit k marks the final valid byte; bytes [k:0] are kept.
      if (enc_onehot) beat_strb = (enc << 1) - STRB_ONE;
    end
  end

  // Gated by reset as well so the pop strobe reads low while held in reset.
  assign fifo_rd_en = axi_aresetn && !fifo_empty && ((state == ST_HDR) || buf_in_ready);
  assign hdr_pop    = fifo_rd_en && (state == ST_HDR);
  assign data_pop   = fifo_rd_en && (state == ST_DATA);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state     <= ST_HDR;
      tuser_q   <= '0;
      ts_q      <= '0;
      err_count <= '0;
    end else begin
      if (hdr_pop) begin
        state   <= ST_DATA;
        tuser_q <= TUSER_W'(fifo_dout[TUSER_LO +: HDR_FIELD_W]);
        ts_q    <= fifo_dout[TS_LO +: HDR_FIELD_W];
      end
      if (data_pop && beat_last) state <= ST_HDR;
      if (data_pop && malformed && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pkt_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end

  assign pkt_timestamp = ts_q;

  axis_out_buf #(
    .W (BEAT_W)
  ) u_out_buf (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .in_valid    (data_pop),
    .in_data     ({tuser_q, beat_last, beat_strb, fifo_dout[DATA_W-1:0]}),
    .in_ready    (buf_in_ready),
    .out_valid   (m_axis_tvalid),
    .out_data    (buf_out),
    .out_ready   (m_axis_tready)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tstrb, m_axis_tdata} = buf_out;

endmodule

// File: tb/tb_fifo_to_axis.sv
// Randomised and directed stimulus for fifo_to_axis against a packet-level
// reference model; the FIFO itself is a queue owned by the bench.
module tb_fifo_to_axis;

  logic         axi_aclk = 1'b0;
  logic         axi_aresetn;
  logic [287:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [63:0]  pkt_timestamp;
  logic [31:0]  pkt_count;
  logic [15:0]  err_count;

  fifo_to_axis dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_timestamp (pkt_timestamp),
    .pkt_count     (pkt_count),
    .err_count     (err_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic [287:0] w;
    bit           hdr;
  } fword_t;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
    logic [127:0] tuser;
    logic [63:0]  ts;
    bit           chk_ts;
  } beat_t;

  fword_t fq[$];
  beat_t  eq[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_hs = 0;
  int          exp_pkts = 0;
  int          exp_err = 0;
  logic [63:0] last_ts = '0;
  int          tr_mode = 0;
  int          em_mode = 0;
  int          stall_at = 0;
  int          stall_len = 0;
  int          stall_cnt = 0;
  bit          gate = 1'b0;

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Byte-enable rule: single set bit k keeps bytes 0..k; anything else keeps all.
  function automatic logic [31:0] exp_strb(input logic [31:0] e);
    if ($countones(e) != 1) return 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++)
      if (e[i]) return 32'((64'd1 << (i + 1)) - 64'd1);
    return 32'h0;
  endfunction

  task automatic add_pkt(input logic [63:0] tuser, input logic [63:0] ts,
                         input int n_full, input logic [31:0] last_enc);
    fword_t       f;
    beat_t        b;
    logic [255:0] d;
    int           nb;
    nb = n_full + 1;
    f.hdr = 1'b1;
    f.w = {$urandom(), rand256()};
    f.w[63:0] = tuser;
    f.w[127:64] = ts;
    fq.push_back(f);
    for (int i = 0; i < nb; i++) begin
      d = rand256();
      f.hdr = 1'b0;
      f.w = {(i == n_full) ? last_enc : 32'h0, d};
      fq.push_back(f);
      b.data = d;
      b.strb = (i == n_full) ? exp_strb(last_enc) : 32'hFFFF_FFFF;
      b.last = (i == n_full);
      b.tuser = {64'h0, tuser};
      b.ts = ts;
      b.chk_ts = (i == 0) && (nb >= 3);
      eq.push_back(b);
    end
    exp_pkts++;
    if ($countones(last_enc) != 1) exp_err++;
    last_ts = ts;
  endtask

  task automatic drive_inputs();
    fifo_empty = (fq.size() == 0) || gate;
    fifo_dout = (fq.size() != 0) ? fq[0].w : 288'h0;
  endtask

  task automatic step();
    logic         rd;
    logic         hs;
    logic         hold;
    logic [416:0] held;
    fword_t       popped;
    beat_t        b;
    rd = fifo_rd_en;
    hs = m_axis_tvalid && m_axis_tready;
    hold = m_axis_tvalid && !m_axis_tready;
    held = {m_axis_tuser, m_axis_tlast, m_axis_tstrb, m_axis_tdata};
    check("rd_en_while_empty", 288'(rd && fifo_empty), 288'd0);
    if (hs) begin
      check("beat_expected", 288'(eq.size() > 0), 288'd1);
      if (eq.size() > 0) begin
        b = eq.pop_front();
        check("tdata", 288'(m_axis_tdata), 288'(b.data));
        check("tstrb", 288'(m_axis_tstrb), 288'(b.strb));
        check("tlast", 288'(m_axis_tlast), 288'(b.last));
        check("tuser", 288'(m_axis_tuser), 288'(b.tuser));
        if (b.chk_ts) check("beat_timestamp", 288'(pkt_timestamp), 288'(b.ts));
      end
      n_hs++;
    end
    @(posedge axi_aclk);
    #1;
    cyc++;
    if (rd && fq.size() != 0) begin
      popped = fq.pop_front();
      if (!popped.hdr) check("pop_to_tvalid", 288'(m_axis_tvalid), 288'd1);
    end
    if (hold) begin
      check("hold_tvalid", 288'(m_axis_tvalid), 288'd1);
      check("hold_beat", 288'({m_axis_tuser, m_axis_tlast, m_axis_tstrb, m_axis_tdata} == held), 288'd1);
    end
    case (tr_mode)
      1: m_axis_tready = ($urandom_range(0, 3) != 0);
      2: begin
        if (n_hs == stall_at && stall_cnt < stall_len) begin
          m_axis_tready = 1'b0;
          stall_cnt++;
        end else begin
          m_axis_tready = 1'b1;
        end
      end
      default: m_axis_tready = 1'b1;
    endcase
    case (em_mode)
      1: gate = cyc[0];
      2: gate = ($urandom_range(0, 2) == 0);
      default: gate = 1'b0;
    endcase
    drive_inputs();
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((eq.size() != 0 || fq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drain"}, 288'(eq.size() + fq.size()), 288'd0);
    repeat (4) step();
    check({tag, "_pkt_count"}, 288'(pkt_count), 288'(exp_pkts));
    check({tag, "_err_count"}, 288'(err_count), 288'(exp_err));
    check({tag, "_timestamp"}, 288'(pkt_timestamp), 288'(last_ts));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tvalid"}, 288'(m_axis_tvalid), 288'd0);
    check({tag, "_tlast"}, 288'(m_axis_tlast), 288'd0);
    check({tag, "_tdata"}, 288'(m_axis_tdata), 288'd0);
    check({tag, "_tstrb"}, 288'(m_axis_tstrb), 288'd0);
    check({tag, "_tuser"}, 288'(m_axis_tuser), 288'd0);
    check({tag, "_ts"}, 288'(pkt_timestamp), 288'd0);
    check({tag, "_pkt_count"}, 288'(pkt_count), 288'd0);
    check({tag, "_err_count"}, 288'(err_count), 288'd0);
    check({tag, "_rd_en"}, 288'(fifo_rd_en), 288'd0);
  endtask

  initial begin
    logic [31:0] enc;
    int          bi;
    int          bj;

    // Reset state, with a word presented to prove the pop strobe stays low.
    axi_aresetn = 1'b0;
    m_axis_tready = 1'b1;
    fifo_empty = 1'b0;
    fifo_dout = {32'h0, rand256()};
    #2;
    check_all_zero("reset");
    @(posedge axi_aclk);
    #1;
    drive_inputs();
    #2;
    axi_aresetn = 1'b1;
    #1;

    // Three-beat packet ending in byte 7.
    tr_mode = 0; em_mode = 0;
    add_pkt(64'h40_0001, 64'h10, 2, 32'h0000_0080);
    drain("basic", 200);

    // Last beat using the top strobe bit, then another packet right behind it.
    add_pkt(64'h1234, 64'h20, 1, 32'h8000_0000);
    add_pkt(64'h5678, 64'h21, 0, 32'h0000_0001);
    drain("top_bit", 200);

    // Malformed last marker followed by a packet that must still parse.
    add_pkt(64'h9ABC, 64'h30, 1, 32'h0000_0003);
    add_pkt(64'hDEF0, 64'h31, 3, 32'h0000_0400);
    drain("malformed", 200);

    // Ten data words, consumer stalls five cycles at the fourth beat.
    tr_mode = 2; stall_at = 3; stall_len = 5; stall_cnt = 0; n_hs = 0;
    add_pkt(64'hAAAA, 64'h40, 9, 32'h0000_8000);
    drain("stall", 300);

    // Three back-to-back packets with the FIFO flickering empty.
    tr_mode = 0; em_mode = 1;
    add_pkt(64'h0101, 64'h51, 3, 32'h0000_0002);
    add_pkt(64'h0202, 64'h52, 2, 32'h0001_0000);
    add_pkt(64'h0303, 64'h53, 4, 32'h0000_0010);
    drain("toggle", 300);

    // Randomised packets, random back-pressure and FIFO gaps.
    tr_mode = 1; em_mode = 2;
    for (int p = 0; p < 16; p++) begin
      case ($urandom_range(0, 2))
        0: enc = 32'h1 << $urandom_range(0, 31);
        1: begin
          bi = $urandom_range(0, 31);
          bj = (bi + 1 + $urandom_range(0, 30)) % 32;
          enc = (32'h1 << bi) | (32'h1 << bj);
        end
        default: enc = $urandom() | 32'h8000_0000;
      endcase
      add_pkt({$urandom(), $urandom()}, {$urandom(), $urandom()}, $urandom_range(0, 5), enc);
    end
    drain("random", 3000);

    // Reset in the middle of a packet, then a fresh packet after release.
    tr_mode = 1; em_mode = 0;
    add_pkt(64'hBEEF, 64'h60, 8, 32'h0000_0100);
    repeat (6) step();
    #1;
    axi_aresetn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    fq.delete();
    eq.delete();
    exp_pkts = 0;
    exp_err = 0;
    last_ts = '0;
    drive_inputs();
    @(posedge axi_aclk);
    #3;
    axi_aresetn = 1'b1;
    #1;
    add_pkt(64'hCAFE, 64'h70, 2, 32'h0000_0004);
    drain("after_reset", 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_to_axis.md
FIFO_TO_AXIS -- requirements
Module: fifo_to_axis

Interface
REQ-001 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256, AXI Stream data width.
REQ-002 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128, tuser width; must be >= 64.
REQ-003 SHALL have parameter FIFO_DATA_WIDTH, default C_M_AXIS_DATA_WIDTH+C_M_AXIS_DATA_WIDTH/8, packed FIFO word width {enc_strb, data}.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: axi_aclk  input  1  sole clock.
REQ-005 axi_aresetn  input  1  asynchronous active-low reset.
REQ-006 fifo_dout  input  FIFO_DATA_WIDTH  head-of-FIFO word, first-word-fall-through, valid while !fifo_empty.
REQ-007 fifo_empty  input  1  FIFO empty.
REQ-008 fifo_rd_en  output  1  pops head word.
REQ-009 m_axis_tdata / m_axis_tstrb / m_axis_tuser  output  DATA / DATA/8 / TUSER  stream beat.
REQ-010 m_axis_tvalid  output  1; m_axis_tready  input  1; m_axis_tlast  output  1.
REQ-011 pkt_timestamp  output  64  timestamp of packet currently on output, held until next header.
REQ-012 pkt_count  output  32  packets emitted (tlast handshakes), wraps.
REQ-013 err_count  output  16  malformed words seen, saturates at 0xFFFF.

Function
REQ-014 Word format: header word = data[63:0] tuser, data[127:64] timestamp, enc_strb 0; data word enc_strb 0 = full non-last beat; enc_strb one-hot = last beat.
REQ-015 States HDR, DATA; reset state HDR.
REQ-016 HDR: when !fifo_empty, SHALL pop word in same cycle (no output beat), latch tuser[63:0] (upper tuser bits 0) and timestamp, go to DATA next cycle; enc_strb ignored.
REQ-017 DATA: SHALL pop word when !fifo_empty and output buffer has a free entry; popped word becomes an output beat.
REQ-018 Data beat decode: enc 0 -> tstrb all ones, tlast 0; enc one-hot bit k -> tstrb bits [k:0] set, tlast 1, next state HDR.
REQ-019 Malformed enc (nonzero, not one-hot) SHALL emit beat with tstrb all ones, tlast 1, err_count+1, next state HDR.
REQ-020 m_axis_tuser SHALL equal the latched header tuser on every beat of its packet.
REQ-021 Output buffer: 2 entries, registered outputs; latency pop -> tvalid exactly 1 cycle; sustained 1 beat/cycle with tready high.
REQ-022 tvalid, once high, SHALL hold and beat SHALL remain stable until tready.
REQ-023 fifo_rd_en SHALL never assert when fifo_empty is high.
REQ-024 Header pop SHALL proceed while previous packet's beats still drain from the buffer.
REQ-025 pkt_count SHALL increment on tvalid&&tready&&tlast; pkt_timestamp SHALL update at header pop (may precede drain of previous packet's last beat by at most 2 cycles).

Reset
REQ-026 On axi_aresetn low, asynchronously: state HDR, buffer empty, all outputs 0 (tvalid, tlast, fifo_rd_en, counters, tdata, tstrb, tuser, pkt_timestamp).
REQ-027 Reset mid-packet SHALL discard partial packet; first word after release is treated as header.

Structure
REQ-028 Shared package SHALL hold state encodings and header field offsets (TUSER_LO=0, TS_LO=64, field width 64), shared with the writer side.
REQ-029 Output buffer SHALL be sub-module axis_out_buf (2-entry skid buffer).

Verification
REQ-030 Header tuser 0x400001, ts 0x10; two enc-0 words; last enc 0x00000080 -> 3 beats, tstrb FFFFFFFF,FFFFFFFF,000000FF, tlast on beat 3, tuser 0x400001 all beats, pkt_count 1.
REQ-031 Last enc 0x80000000 -> tstrb 0xFFFFFFFF, tlast 1; next word consumed as header.
REQ-032 10-word packet, tready low 5 cycles at beat 4 -> no beat lost/duplicated, fifo_rd_en low while buffer full, output stable.
REQ-033 Last enc 0x00000003 -> beat tstrb 0xFFFFFFFF, tlast 1, err_count 1; following word decoded as header.
REQ-034 Back-to-back 3 packets, fifo_empty toggling every other cycle -> correct packet boundaries, pkt_count 3, per-packet tuser/pkt_timestamp.
REQ-035 Reset asserted mid-packet -> all outputs 0 immediately; after release, next word taken as header.
